// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types and helpers for the CPU-to-peripheral bus fabric.
package soc_bus_pkg;

    // Fabric access phases: accept a request, hold a slave strobe, answer the master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    // Read data handed back to the master on any error completion.
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Width of the region index field; a single-slave fabric still decodes one bit
    // so that region 1 is reported as unmapped.
    function automatic int idx_width(input int n_slaves);
        return (n_slaves <= 1) ? 1 : $clog2(n_slaves);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts cycles a bus strobe has been held without completion.
// 'expired' is high during the last allowed cycle (count == TIMEOUT-1), so a strobe
// held from a clear is allowed exactly TIMEOUT cycles.
module bus_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: decodes one CPU data-bus master onto N_SLAVES peripheral ports by
// address region. Each access is IDLE (accept) -> ACCESS (strobe held until the
// slave is ready or the wait budget runs out) -> RESP (one-cycle m_ready).
// Unmapped regions and simultaneous read+write skip ACCESS and answer with an error.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                N_SLAVES     = 4,
    parameter int                REGION_SHIFT = 16,
    parameter int                SLAVE_ADDR_W = 14,
    parameter int                TIMEOUT      = 15,
    parameter logic [DATA_W-1:0] ERR_DATA     = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                         CoreClock,
    input  logic                         ResetN,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_write,
    input  logic                         m_read,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_error,
    output logic [SLAVE_ADDR_W-1:0]      s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [N_SLAVES-1:0]          s_write,
    output logic [N_SLAVES-1:0]          s_read,
    input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [N_SLAVES-1:0]          s_ready,
    output logic [7:0]                   err_count
);

    localparam int IDX_W = idx_width(N_SLAVES);
    // Slave count held one bit wider than the index so N_SLAVES = 2**IDX_W fits.
    localparam logic [IDX_W:0] N_SLAVES_W = (IDX_W + 1)'(N_SLAVES);

    bus_state_t                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      wr_q, wr_d;
    logic [SLAVE_ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]         s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]         m_rdata_q, m_rdata_d;
    logic                      err_q, err_d;
    logic [7:0]                err_count_q, err_count_d;

    logic                      req;
    logic [IDX_W-1:0]          idx_in;
    logic                      unmapped;
    logic [N_SLAVES-1:0]       sel_onehot;
    logic [DATA_W-1:0]         sel_rdata;
    logic                      sel_ready;
    logic                      cnt_clear;
    logic                      cnt_enable;
    logic                      tmo_expired;
    logic                      enter_err;
    logic                      addr_unused;

    assign req      = m_read | m_write;
    assign idx_in   = m_addr[REGION_SHIFT +: IDX_W];
    assign unmapped = ({1'b0, idx_in} >= N_SLAVES_W);

    // Only the word-address field and the region field of m_addr are decoded.
    assign addr_unused = ^m_addr;

    // Decode the latched index into a one-hot select and pick that slave's data.
    always_comb begin
        sel_onehot = '0;
        sel_rdata  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_rdata     = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready from non-selected slaves is masked off.
    assign sel_ready = |(s_ready & sel_onehot);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CoreClock),
        .rst_n   (ResetN),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (tmo_expired)
    );

    // Next-state, request latching, read-data capture and error accounting.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        m_rdata_d   = m_rdata_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        enter_err   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d     = idx_in;
                    wr_d      = m_write;
                    s_addr_d  = m_addr[SLAVE_ADDR_W+1:2];
                    s_wdata_d = m_wdata;
                    if (unmapped || (m_read && m_write)) begin
                        state_d   = RESP;
                        enter_err = 1'b1;
                    end else begin
                        state_d   = ACCESS;
                        err_d     = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked before expiry so a last-cycle ready still succeeds.
                if (sel_ready) begin
                    if (!wr_q) begin
                        m_rdata_d = sel_rdata;
                    end
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (tmo_expired) begin
                    state_d   = RESP;
                    enter_err = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Error data and count are set on entry to RESP so they are valid with m_ready.
        if (enter_err) begin
            err_d     = 1'b1;
            m_rdata_d = ERR_DATA;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // Fabric state and latched access registers.
    always_ff @(posedge CoreClock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            m_rdata_q   <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            m_rdata_q   <= m_rdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // Strobes follow the state register directly, so an async reset drops them at once.
    always_comb begin
        s_read  = '0;
        s_write = '0;
        if (state_q == ACCESS) begin
            if (wr_q) begin
                s_write = sel_onehot;
            end else begin
                s_read = sel_onehot;
            end
        end
    end

    assign m_ready   = (state_q == RESP);
    assign m_error   = (state_q == RESP) && err_q;
    assign m_rdata   = m_rdata_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Testbench for soc_bus_fabric: directed vector table, randomized accesses against a
// transaction-level reference, error-count saturation, reset mid-access, and a
// one-hot decode sweep over N_SLAVES = 1, 3 and 16.
module tb_soc_bus_fabric;

    localparam int          NS   = 4;
    localparam int          TMO  = 15;
    localparam int          RS   = 16;
    localparam int          IW   = 2;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main instance (N_SLAVES = 4)
    logic [31:0]     m_addr = '0;
    logic [31:0]     m_wdata = '0;
    logic            m_write = 1'b0;
    logic            m_read = 1'b0;
    logic [31:0]     m_rdata;
    logic            m_ready;
    logic            m_error;
    logic [13:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [NS-1:0]   s_write;
    logic [NS-1:0]   s_read;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]   s_ready;
    logic [7:0]      err_count;

    // slave behaviour: lat = strobe cycle on which ready rises (0 = never)
    int          lat   [NS];
    logic [31:0] sdata [NS];
    int          hc    [NS];
    logic [NS-1:0] noise = '0;

    int n_vec  = 0;
    int n_fail = 0;
    int          cnt_ref = 0;
    logic [31:0] rdata_ref = '0;

    always #5 clk = ~clk;

    soc_bus_fabric #(
        .DATA_W(32), .ADDR_W(32), .N_SLAVES(NS), .REGION_SHIFT(RS),
        .SLAVE_ADDR_W(14), .TIMEOUT(TMO), .ERR_DATA(ERRD)
    ) u_dut (
        .CoreClock(clk), .ResetN(rst_n),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write), .m_read(m_read),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write), .s_read(s_read),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_count(err_count)
    );

    // count how many cycles each slave has been strobed
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst_n)                      hc[i] <= 0;
            else if (s_read[i] | s_write[i]) hc[i] <= hc[i] + 1;
            else                             hc[i] <= 0;
        end
    end

    always_comb begin
        s_rdata = '0;
        s_ready = '0;
        for (int i = 0; i < NS; i++) begin
            s_rdata[i*32 +: 32] = sdata[i];
            if (s_read[i] | s_write[i]) s_ready[i] = (lat[i] != 0) && (hc[i] >= lat[i] - 1);
            else                        s_ready[i] = noise[i];
        end
    end

    // sweep instances: every slave always ready, slave i returns C0DE_0000 | i
    logic [31:0] sw_addr = '0;
    logic        sw_read = 1'b0;
    logic        sw_write = 1'b0;
    logic [31:0] sw_wdata = '0;

    logic [31:0] n1_rdata, n3_rdata, n16_rdata;
    logic        n1_ready, n3_ready, n16_ready, n1_error, n3_error, n16_error;
    logic [13:0] n1_saddr, n3_saddr, n16_saddr;
    logic [31:0] n1_swdata, n3_swdata, n16_swdata;
    logic [0:0]  n1_write, n1_read;
    logic [2:0]  n3_write, n3_read;
    logic [15:0] n16_write, n16_read;
    logic [31:0]  n1_srdata;
    logic [95:0]  n3_srdata;
    logic [511:0] n16_srdata;
    logic [7:0]  n1_cnt, n3_cnt, n16_cnt;

    assign n1_srdata = 32'hC0DE_0000;
    for (genvar g = 0; g < 3; g++) begin : g_n3
        assign n3_srdata[g*32 +: 32] = 32'hC0DE_0000 | 32'(g);
    end
    for (genvar g = 0; g < 16; g++) begin : g_n16
        assign n16_srdata[g*32 +: 32] = 32'hC0DE_0000 | 32'(g);
    end

    soc_bus_fabric #(.N_SLAVES(1)) u_n1 (
        .CoreClock(clk), .ResetN(rst_n), .m_addr(sw_addr), .m_wdata(sw_wdata),
        .m_write(sw_write), .m_read(sw_read), .m_rdata(n1_rdata), .m_ready(n1_ready),
        .m_error(n1_error), .s_addr(n1_saddr), .s_wdata(n1_swdata), .s_write(n1_write),
        .s_read(n1_read), .s_rdata(n1_srdata), .s_ready(1'b1), .err_count(n1_cnt)
    );
    soc_bus_fabric #(.N_SLAVES(3)) u_n3 (
        .CoreClock(clk), .ResetN(rst_n), .m_addr(sw_addr), .m_wdata(sw_wdata),
        .m_write(sw_write), .m_read(sw_read), .m_rdata(n3_rdata), .m_ready(n3_ready),
        .m_error(n3_error), .s_addr(n3_saddr), .s_wdata(n3_swdata), .s_write(n3_write),
        .s_read(n3_read), .s_rdata(n3_srdata), .s_ready(3'b111), .err_count(n3_cnt)
    );
    soc_bus_fabric #(.N_SLAVES(16)) u_n16 (
        .CoreClock(clk), .ResetN(rst_n), .m_addr(sw_addr), .m_wdata(sw_wdata),
        .m_write(sw_write), .m_read(sw_read), .m_rdata(n16_rdata), .m_ready(n16_ready),
        .m_error(n16_error), .s_addr(n16_saddr), .s_wdata(n16_swdata), .s_write(n16_write),
        .s_read(n16_read), .s_rdata(n16_srdata), .s_ready(16'hFFFF), .err_count(n16_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One master access on the main instance, checked against expected results.
    // exp_strb = number of strobe cycles (0 = no strobe at all).
    task automatic run_xact(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rd, input logic wr, input int exp_strb,
                            input logic exp_err, input logic [31:0] exp_rdata,
                            input logic [7:0] exp_cnt);
        int          strb_cycles = 0;
        int          done_at = 0;
        logic [3:0]  exp_oh;
        logic [7:0]  exp_pat;
        logic [7:0]  got_pat;
        logic [31:0] got_rdata = '0;
        logic        got_err = 1'b0;
        logic [7:0]  got_cnt = '0;
        exp_oh  = 4'b0001 << addr[17:16];
        exp_pat = rd ? {exp_oh, 4'b0000} : {4'b0000, exp_oh};
        got_pat = exp_pat;
        m_addr = addr; m_wdata = wdata; m_read = rd; m_write = wr;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(posedge clk); #1;
            if ((s_read != 0) || (s_write != 0)) begin
                strb_cycles++;
                if ({s_read, s_write} != exp_pat) got_pat = {s_read, s_write};
                if (strb_cycles == 1) begin
                    check({tag, "_s_addr"}, 64'(s_addr), 64'(addr[15:2]));
                    check({tag, "_s_wdata"}, 64'(s_wdata), 64'(wdata));
                end
                m_addr = $urandom; m_wdata = $urandom;   // must have no effect now
            end
            if (m_ready) begin
                done_at   = k;
                got_rdata = m_rdata;
                got_err   = m_error;
                got_cnt   = err_count;
                m_read = 1'b0; m_write = 1'b0;
            end
        end
        m_read = 1'b0; m_write = 1'b0;
        check({tag, "_latency"}, 64'(done_at), 64'((exp_strb == 0) ? 1 : exp_strb + 1));
        check({tag, "_strobe_cycles"}, 64'(strb_cycles), 64'(exp_strb));
        if (exp_strb > 0) check({tag, "_strobe_pattern"}, 64'(got_pat), 64'(exp_pat));
        check({tag, "_m_error"}, 64'(got_err), 64'(exp_err));
        check({tag, "_m_rdata"}, 64'(got_rdata), 64'(exp_rdata));
        check({tag, "_err_count"}, 64'(got_cnt), 64'(exp_cnt));
        @(posedge clk); #1;
        check({tag, "_ready_pulse"}, 64'(m_ready), 64'(0));
    endtask

    // Randomized access judged by a transaction-level reference of the fabric rules.
    task automatic rand_xact();
        logic [31:0] addr, wdata, sd;
        logic        rd, wr, eerr, mapped;
        int          sel, l, idx, estrb;
        sel   = $urandom_range(0, 9);
        rd    = (sel <= 5);
        wr    = (sel == 0) || (sel > 5);
        addr  = {14'd0, 2'($urandom_range(0, 3)), 16'($urandom)};
        wdata = $urandom;
        sd    = $urandom;
        l     = $urandom_range(0, 17);
        idx   = int'((addr >> RS) & 32'((1 << IW) - 1));
        lat[idx]   = l;
        sdata[idx] = sd;
        noise      = 4'($urandom);
        mapped     = (idx < NS);
        if (!mapped || (rd && wr))   begin eerr = 1'b1; estrb = 0;   end
        else if (l >= 1 && l <= TMO) begin eerr = 1'b0; estrb = l;   end
        else                         begin eerr = 1'b1; estrb = TMO; end
        if (eerr)    rdata_ref = ERRD;
        else if (rd) rdata_ref = sd;
        if (eerr && cnt_ref < 255) cnt_ref++;
        run_xact("rnd", addr, wdata, rd, wr, estrb, eerr, rdata_ref, 8'(cnt_ref));
    endtask

    task automatic sweep_check(input int ns, input int r, input int phase, input logic [15:0] strb,
                               input logic rdy, input logic err, input logic [31:0] rdata);
        int   iw;
        logic mapped;
        string t;
        iw = (ns <= 1) ? 1 : $clog2(ns);
        if (r >= (1 << iw)) return;
        mapped = (r < ns);
        t = $sformatf("sweep_n%0d_r%0d_p%0d", ns, r, phase);
        if (phase == 1) begin
            check({t, "_strobe"}, 64'(strb), mapped ? 64'(16'(1) << r) : 64'(0));
            check({t, "_ready"}, 64'(rdy), 64'(!mapped));
            check({t, "_error"}, 64'(err), 64'(!mapped));
        end else begin
            check({t, "_ready"}, 64'(rdy), 64'(mapped));
            if (mapped) begin
                check({t, "_error"}, 64'(err), 64'(0));
                check({t, "_rdata"}, 64'(rdata), 64'(32'hC0DE_0000 | 32'(r)));
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          lat;
        logic [31:0] sdata;
        int          exp_strb;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit seen_ready;
        tbl[0] = '{32'h0001_0008, 32'h0000_0000, 1'b1, 1'b0, 1,  32'h1234_5678, 1,  1'b0, 32'h1234_5678, 8'd0};
        tbl[1] = '{32'h0002_0004, 32'hA5A5_0001, 1'b0, 1'b1, 5,  32'h7777_7777, 5,  1'b0, 32'h1234_5678, 8'd0};
        tbl[2] = '{32'h0003_0000, 32'h0000_0000, 1'b1, 1'b0, 0,  32'h3333_3333, 15, 1'b1, 32'hDEAD_BEEF, 8'd1};
        tbl[3] = '{32'h0003_0000, 32'h0000_0000, 1'b1, 1'b0, 15, 32'h0BAD_F00D, 15, 1'b0, 32'h0BAD_F00D, 8'd1};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1,  32'h4444_4444, 0,  1'b1, 32'hDEAD_BEEF, 8'd2};
        tbl[5] = '{32'h0000_0010, 32'h1111_2222, 1'b0, 1'b1, 3,  32'h5555_5555, 3,  1'b0, 32'hDEAD_BEEF, 8'd2};
        tbl[6] = '{32'h0001_0010, 32'h0000_0000, 1'b1, 1'b0, 16, 32'h6666_6666, 15, 1'b1, 32'hDEAD_BEEF, 8'd3};
        tbl[7] = '{32'h0001_FFFC, 32'h0000_0000, 1'b1, 1'b0, 2,  32'hCAFE_F00D, 2,  1'b0, 32'hCAFE_F00D, 8'd3};
        tbl[8] = '{32'h0002_0000, 32'h9999_0000, 1'b0, 1'b1, 0,  32'h8888_8888, 15, 1'b1, 32'hDEAD_BEEF, 8'd4};
        for (int i = 0; i < NS; i++) begin lat[i] = 1; sdata[i] = '0; end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_ready", 64'(m_ready), 64'(0));
        check("rst_m_error", 64'(m_error), 64'(0));
        check("rst_m_rdata", 64'(m_rdata), 64'(0));
        check("rst_strobes", 64'({s_read, s_write}), 64'(0));
        check("rst_s_addr", 64'(s_addr), 64'(0));
        check("rst_s_wdata", 64'(s_wdata), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed table
        for (int v = 0; v < 9; v++) begin
            int idx;
            idx = int'(tbl[v].addr[17:16]);
            lat[idx]   = tbl[v].lat;
            sdata[idx] = tbl[v].sdata;
            noise      = 4'($urandom);
            run_xact($sformatf("tbl%0d", v), tbl[v].addr, tbl[v].wdata, tbl[v].rd, tbl[v].wr,
                     tbl[v].exp_strb, tbl[v].exp_err, tbl[v].exp_rdata, tbl[v].exp_cnt);
        end
        rdata_ref = ERRD;
        cnt_ref   = 4;

        // randomized accesses
        for (int n = 0; n < 150; n++) rand_xact();

        // error count saturation with illegal read+write requests
        for (int n = 0; n < 300; n++) begin
            if (cnt_ref < 255) cnt_ref++;
            run_xact("sat", 32'h0001_0000, 32'h0, 1'b1, 1'b1, 0, 1'b1, ERRD, 8'(cnt_ref));
        end
        check("sat_final_err_count", 64'(err_count), 64'(255));

        // reset while slave 0 is being written
        lat[0]  = 0;
        m_addr  = 32'h0000_0020; m_wdata = 32'h1357_2468; m_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_strobe_before", 64'(s_write), 64'(4'b0001));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_strobe_drop", 64'({s_read, s_write}), 64'(0));
        check("midrst_err_count", 64'(err_count), 64'(0));
        check("midrst_m_rdata", 64'(m_rdata), 64'(0));
        check("midrst_s_addr", 64'(s_addr), 64'(0));
        m_write = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (m_ready) seen_ready = 1'b1;
        end
        check("midrst_no_completion", 64'(seen_ready), 64'(0));
        check("midrst_err_count_after", 64'(err_count), 64'(0));

        // parameter sweep: request held for the acceptance edge only
        for (int r = 0; r < 16; r++) begin
            sw_addr = (32'(r) << 16) | 32'h8;
            sw_read = 1'b1;
            @(posedge clk); #1;
            sw_read = 1'b0;
            sweep_check(1,  r, 1, 16'(n1_read),  n1_ready,  n1_error,  n1_rdata);
            sweep_check(3,  r, 1, 16'(n3_read),  n3_ready,  n3_error,  n3_rdata);
            sweep_check(16, r, 1, n16_read,      n16_ready, n16_error, n16_rdata);
            @(posedge clk); #1;
            sweep_check(1,  r, 2, 16'(n1_read),  n1_ready,  n1_error,  n1_rdata);
            sweep_check(3,  r, 2, 16'(n3_read),  n3_ready,  n3_error,  n3_rdata);
            sweep_check(16, r, 2, n16_read,      n16_ready, n16_error, n16_rdata);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
